// File: rtl/buffer.sv
// Synchronous FIFO with a circular store, registered read data and 1-cycle read latency.
// Optional overflow/underflow pulse flags are compiled in with BUFFER_ERR_FLAG_EN.
module buffer #(
  parameter int unsigned DASize  = 10,
  parameter int unsigned BUFSize = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DASize-1:0] buf_in,
  output logic [DASize-1:0] buf_out,
  output logic              buf_empty,
`ifdef BUFFER_ERR_FLAG_EN
  output logic              buf_ovf,
  output logic              buf_udf,
`endif
  output logic              buf_full
);

  localparam int unsigned PtrW = $clog2(BUFSize);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(BUFSize - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BUFSize);

  logic [DASize-1:0] mem_q [BUFSize];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DASize-1:0] out_q, out_d;
  logic              wr_ok, rd_ok;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == CntFull);
  assign buf_out   = out_q;

  // A write into a full buffer is accepted only if a read frees a slot on the same edge.
  // A read on an empty buffer is never accepted, so there is no write-through bypass.
  always_comb begin
    wr_ok    = write_en & (~buf_full | read_en);
    rd_ok    = read_en & ~buf_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
      out_d    = mem_q[rd_ptr_q];
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  // Storage is not cleared by reset; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem_q[wr_ptr_q] <= buf_in;
    end
  end

`ifdef BUFFER_ERR_FLAG_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = write_en & buf_full & ~read_en;
    udf_d = read_en & buf_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign buf_ovf = ovf_q;
  assign buf_udf = udf_q;
`endif

endmodule

// File: tb/tb_buffer.sv
// Scoreboard bench for buffer: a queue-based reference model predicts each cycle's outputs,
// a separate monitor pops and compares after every rising edge.
module tb_buffer;

  localparam int unsigned DASize  = 10;
  localparam int unsigned BUFSize = 4;

  typedef struct packed {
    logic [DASize-1:0] out;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              udf;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_en;
  logic              read_en;
  logic [DASize-1:0] buf_in;
  logic [DASize-1:0] buf_out;
  logic              buf_empty;
  logic              buf_full;
`ifdef BUFFER_ERR_FLAG_EN
  logic              buf_ovf;
  logic              buf_udf;
`endif

  int checks   = 0;
  int failures = 0;

  rec_t              exp_q [$];
  logic [DASize-1:0] model_q [$];
  logic [DASize-1:0] model_out = '0;

  buffer #(
    .DASize (DASize),
    .BUFSize(BUFSize)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write_en (write_en),
    .read_en  (read_en),
    .buf_in   (buf_in),
    .buf_out  (buf_out),
    .buf_empty(buf_empty),
`ifdef BUFFER_ERR_FLAG_EN
    .buf_ovf  (buf_ovf),
    .buf_udf  (buf_udf),
`endif
    .buf_full (buf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and push the outputs the model predicts after the next edge.
  task automatic step(input logic rstn, input logic we, input logic re,
                      input logic [DASize-1:0] d);
    rec_t r;
    bit   rd, wr;
    int   n;
    @(negedge clk);
    rst      = rstn;
    write_en = we;
    read_en  = re;
    buf_in   = d;
    n        = model_q.size();
    r.ovf    = 1'b0;
    r.udf    = 1'b0;
    if (!rstn) begin
      model_q.delete();
      model_out = '0;
    end else begin
      rd    = re && (n > 0);
      wr    = we && ((n < BUFSize) || re);
      r.ovf = we && (n == BUFSize) && !re;
      r.udf = re && (n == 0);
      if (rd) model_out = model_q.pop_front();
      if (wr) model_q.push_back(d);
    end
    r.out   = model_out;
    r.empty = (model_q.size() == 0);
    r.full  = (model_q.size() == BUFSize);
    exp_q.push_back(r);
  endtask

  initial begin : monitor
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("buf_out", 32'(buf_out), 32'(e.out));
        check("buf_empty", 32'(buf_empty), 32'(e.empty));
        check("buf_full", 32'(buf_full), 32'(e.full));
`ifdef BUFFER_ERR_FLAG_EN
        check("buf_ovf", 32'(buf_ovf), 32'(e.ovf));
        check("buf_udf", 32'(buf_udf), 32'(e.udf));
`endif
      end
    end
  end

  initial begin : stimulus
    rst      = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    buf_in   = '0;

    // Reset, then read on empty.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    // Fill, overflow with 15, drain, extra read on empty.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, DASize'(10 + i));
    step(1'b1, 1'b1, 1'b0, DASize'(15));
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0);
    // Refill, simultaneous read/write of 20 while full, drain across the pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, DASize'(10 + i));
    step(1'b1, 1'b1, 1'b1, DASize'(20));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0);
    // Simultaneous read/write on empty performs only the write.
    step(1'b1, 1'b1, 1'b1, DASize'(7));
    step(1'b1, 1'b0, 1'b1, '0);
    // Reset with two words stored.
    step(1'b1, 1'b1, 1'b0, DASize'(1));
    step(1'b1, 1'b1, 1'b0, DASize'(2));
    step(1'b0, 1'b1, 1'b1, DASize'(3));
    step(1'b1, 1'b0, 1'b1, '0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 5), DASize'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer.md
BUFFER -- requirements
Module: buffer

Interface
REQ-001 SHALL have parameter DASize, default 10, data word width in bits.
REQ-002 SHALL have parameter BUFSize, default 4, storage depth in words; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port write_en, input, 1 bit: write request, sampled on the clk rising edge.
REQ-006 SHALL have port read_en, input, 1 bit: read request, sampled on the clk rising edge.
REQ-007 SHALL have port buf_in, input, DASize bits: write data.
REQ-008 SHALL have port buf_out, output, DASize bits: registered read data.
REQ-009 SHALL have port buf_empty, output, 1 bit: high when zero words are stored.
REQ-010 SHALL have port buf_full, output, 1 bit: high when BUFSize words are stored.

Function
REQ-011 SHALL behave as a first-in first-out queue: words leave in the order they were written.
REQ-012 SHALL use a circular store with write pointer and read pointer, each clog2(BUFSize) bits, plus an occupancy count of clog2(BUFSize)+1 bits.
REQ-013 SHALL wrap each pointer from BUFSize-1 to 0 on increment.
REQ-014 SHALL accept a write when write_en=1 and (buf_full=0 or read_en=1): store buf_in at the write pointer and increment the write pointer.
REQ-015 SHALL accept a read when read_en=1 and buf_empty=0: load buf_out with the word at the read pointer on that edge and increment the read pointer, giving 1-cycle read latency.
REQ-016 SHALL ignore a write when full and read_en=0: data dropped, no state change.
REQ-017 SHALL ignore a read when empty: buf_out holds its value, no pointer change.
REQ-018 SHALL NOT bypass data: a simultaneous read and write on an empty buffer performs only the write.
REQ-019 SHALL leave the count unchanged when a read and a write are both accepted; otherwise count +1 per accepted write and -1 per accepted read.
REQ-020 SHALL hold buf_out between accepted reads.
REQ-021 SHALL derive buf_empty (count==0) and buf_full (count==BUFSize) combinationally from the registered count.
REQ-022 SHALL treat X or unused buf_in as don't-care when write_en=0.

Reset
REQ-023 SHALL, on a rising clk edge with rst=0, set both pointers and the count to 0 and buf_out to 0, giving buf_empty=1 and buf_full=0.
REQ-024 SHALL give reset priority over write_en and read_en; a reset in mid-operation discards all stored words.
REQ-025 SHALL NOT require the storage array contents to be cleared by reset.

Configuration
REQ-026 SHALL compile in, when macro BUFFER_ERR_FLAG_EN is defined, the output ports buf_ovf and buf_udf, 1 bit each, registered.
REQ-027 SHALL, with BUFFER_ERR_FLAG_EN defined, pulse buf_ovf high for one cycle after a dropped write (REQ-016).
REQ-028 SHALL, with BUFFER_ERR_FLAG_EN defined, pulse buf_udf high for one cycle after an ignored read (REQ-017).
REQ-029 SHALL reset buf_ovf and buf_udf to 0.
REQ-030 SHALL, without BUFFER_ERR_FLAG_EN, omit buf_ovf, buf_udf and their logic entirely; all other behaviour is identical in both builds.

Verification
REQ-031 SHALL cover reset: rst=0 for one edge, then read_en=1 on the empty buffer -> buf_out=0, buf_empty=1, buf_full=0; buf_udf pulses when enabled.
REQ-032 SHALL cover fill: write 10, 11, 12, 13 on consecutive cycles -> buf_empty falls after the first write and buf_full rises after the fourth.
REQ-033 SHALL cover overflow: write 15 while full with read_en=0 -> count stays 4; 15 is never read out; buf_ovf pulses when enabled.
REQ-034 SHALL cover drain: read_en=1 for four cycles -> buf_out=10, 11, 12, 13 on successive edges; buf_empty rises after the fourth read.
REQ-035 SHALL cover full plus simultaneous read and write of 20 -> buf_out=10, buf_full stays 1, and 20 is read fifth, exercising pointer wrap.
REQ-036 SHALL cover reset mid-operation: rst=0 with two words stored -> buffer empty on the next cycle, buf_out=0.
